// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: ALU opcode encodings, the zero register, default widths.
package mips_pkg;

  localparam int unsigned DefaultDw = 32;
  localparam int unsigned DefaultRw = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [5:0] {
    AluAdd  = 6'b000000,
    AluSub  = 6'b000001,
    AluAnd  = 6'b000010,
    AluOr   = 6'b000011,
    AluXor  = 6'b000100,
    AluNor  = 6'b000101,
    AluSlt  = 6'b000110,
    AluSltu = 6'b000111,
    AluSll  = 6'b010100
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode inputs, forwarding sources and ALU/EX outputs around the ID/EX register.
interface id_ex_stage_if #(
  parameter int unsigned DW = mips_pkg::DefaultDw,
  parameter int unsigned RW = mips_pkg::DefaultRw
) ();

  logic          id_valid;
  logic [DW-1:0] id_rs_val;
  logic [DW-1:0] id_rt_val;
  logic [DW-1:0] id_imm;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [5:0]    id_aluop;
  logic [4:0]    id_shamt;
  logic          id_alusrc;
  logic          id_regwrite;
  logic          id_memread;
  logic          id_memwrite;
  logic          id_memtoreg;
  logic          flush;

  logic          exmem_regwrite;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_regwrite;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;

  logic [DW-1:0] alu_op1;
  logic [DW-1:0] alu_op2;
  logic [5:0]    alu_aluop;
  logic [4:0]    alu_shamt;
  logic [DW-1:0] ex_store_data;
  logic          ex_valid;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic          ex_memtoreg;
  logic [RW-1:0] ex_rd;
  logic          stall;

  // Upstream pipeline side: drives decode/forwarding, observes EX outputs.
  modport master (
    output id_valid, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd, id_aluop, id_shamt,
    output id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, flush,
    output exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
    input  alu_op1, alu_op2, alu_aluop, alu_shamt, ex_store_data,
    input  ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_rd, stall
  );

  // ID/EX stage side.
  modport slave (
    input  id_valid, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd, id_aluop, id_shamt,
    input  id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, flush,
    input  exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
    output alu_op1, alu_op2, alu_aluop, alu_shamt, ex_store_data,
    output ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_rd, stall
  );

endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register: EX/MEM, then MEM/WB, then register value.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned RW = DefaultRw
) (
  input  logic [RW-1:0] src_i,
  input  logic [DW-1:0] reg_val_i,
  input  logic          exmem_regwrite_i,
  input  logic [RW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_regwrite_i,
  input  logic [RW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_result_i,
  output logic [DW-1:0] val_o
);

  logic exmem_hit;
  logic memwb_hit;

  // Youngest producer wins; the zero register is never forwarded.
  always_comb begin
    exmem_hit = exmem_regwrite_i && (exmem_rd_i != RW'(REG_ZERO)) && (exmem_rd_i == src_i);
    memwb_hit = memwb_regwrite_i && (memwb_rd_i != RW'(REG_ZERO)) && (memwb_rd_i == src_i);
    if (exmem_hit) begin
      val_o = exmem_result_i;
    end else if (memwb_hit) begin
      val_o = memwb_result_i;
    end else begin
      val_o = reg_val_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall generation.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned RW = DefaultRw
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave pipe_if
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [DW-1:0] imm;
    logic [5:0]    aluop;
    logic [4:0]    shamt;
    logic          alusrc;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
  } ex_state_t;

  ex_state_t     st_q, st_d;
  logic          load_use;
  logic          stall;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // Load in EX whose destination the decoding instruction reads; rt only counts when used.
  always_comb begin
    load_use = st_q.valid && st_q.memread && (st_q.rd != RW'(REG_ZERO)) &&
               ((st_q.rd == pipe_if.id_rs) ||
                ((st_q.rd == pipe_if.id_rt) && (!pipe_if.id_alusrc || pipe_if.id_memwrite)));
    stall    = pipe_if.id_valid && load_use;
  end

  // Flush or stall loads an all-zero bubble (aluop zero is ADD); otherwise capture decode.
  always_comb begin
    st_d = '0;
    if (!pipe_if.flush && !stall) begin
      st_d.valid    = pipe_if.id_valid;
      st_d.rs       = pipe_if.id_rs;
      st_d.rt       = pipe_if.id_rt;
      st_d.rd       = pipe_if.id_rd;
      st_d.rs_val   = pipe_if.id_rs_val;
      st_d.rt_val   = pipe_if.id_rt_val;
      st_d.imm      = pipe_if.id_imm;
      st_d.aluop    = pipe_if.id_aluop;
      st_d.shamt    = pipe_if.id_shamt;
      st_d.alusrc   = pipe_if.id_alusrc   && pipe_if.id_valid;
      st_d.regwrite = pipe_if.id_regwrite && pipe_if.id_valid;
      st_d.memread  = pipe_if.id_memread  && pipe_if.id_valid;
      st_d.memwrite = pipe_if.id_memwrite && pipe_if.id_valid;
      st_d.memtoreg = pipe_if.id_memtoreg && pipe_if.id_valid;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_i            (st_q.rs),
    .reg_val_i        (st_q.rs_val),
    .exmem_regwrite_i (pipe_if.exmem_regwrite),
    .exmem_rd_i       (pipe_if.exmem_rd),
    .exmem_result_i   (pipe_if.exmem_result),
    .memwb_regwrite_i (pipe_if.memwb_regwrite),
    .memwb_rd_i       (pipe_if.memwb_rd),
    .memwb_result_i   (pipe_if.memwb_result),
    .val_o            (fwd_rs)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_i            (st_q.rt),
    .reg_val_i        (st_q.rt_val),
    .exmem_regwrite_i (pipe_if.exmem_regwrite),
    .exmem_rd_i       (pipe_if.exmem_rd),
    .exmem_result_i   (pipe_if.exmem_result),
    .memwb_regwrite_i (pipe_if.memwb_regwrite),
    .memwb_rd_i       (pipe_if.memwb_rd),
    .memwb_result_i   (pipe_if.memwb_result),
    .val_o            (fwd_rt)
  );

  // Outputs to the ALU and EX/MEM.
  always_comb begin
    pipe_if.alu_op1       = fwd_rs;
    pipe_if.alu_op2       = st_q.alusrc ? st_q.imm : fwd_rt;
    pipe_if.alu_aluop     = st_q.aluop;
    pipe_if.alu_shamt     = st_q.shamt;
    pipe_if.ex_store_data = fwd_rt;
    pipe_if.ex_valid      = st_q.valid;
    pipe_if.ex_regwrite   = st_q.regwrite;
    pipe_if.ex_memread    = st_q.memread;
    pipe_if.ex_memwrite   = st_q.memwrite;
    pipe_if.ex_memtoreg   = st_q.memtoreg;
    pipe_if.ex_rd         = st_q.rd;
    pipe_if.stall         = stall;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: reference model of the EX slot, directed and random traffic.
module tb_id_ex_stage;

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  aluop;
    logic [4:0]  shamt;
    logic        alusrc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        mww;
    logic [4:0]  mwrd;
    logic [31:0] mwres;
  } stim_t;

  // What instruction currently sits in EX, as the model sees it.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [5:0]  aluop;
    logic [4:0]  shamt;
    logic        alusrc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
  } slot_t;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] store;
    logic [5:0]  aluop;
    logic [4:0]  shamt;
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic [4:0]  rd;
    logic        stall;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk     (clk),
    .reset   (reset),
    .pipe_if (bus)
  );

  int    total = 0;
  int    bad = 0;
  exp_t  sb[$];
  exp_t  mon_e;
  slot_t m, m_nxt;
  bit    m_known = 1'b0;
  bit    nxt_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Value a source register holds once the younger in-flight writers are accounted for.
  function automatic logic [31:0] reg_seen(input logic [4:0] r, input logic [31:0] file_val,
                                           input stim_t s);
    if (r == 5'd0) return file_val;
    if (s.exw && s.exrd == r) return s.exres;
    if (s.mww && s.mwrd == r) return s.mwres;
    return file_val;
  endfunction

  // A load in EX produces data too late for an instruction that consumes its destination.
  function automatic logic needs_stall(input slot_t e, input stim_t s);
    logic uses_rt;
    uses_rt = !s.alusrc || s.memwrite;
    if (!s.id_valid || !e.valid || !e.memread || e.rd == 5'd0) return 1'b0;
    return (e.rd == s.rs) || (uses_rt && e.rd == s.rt);
  endfunction

  function automatic exp_t expect_out(input slot_t e, input stim_t s);
    exp_t  x;
    logic [31:0] rtv;
    rtv        = reg_seen(e.rt, e.rt_val, s);
    x.op1      = reg_seen(e.rs, e.rs_val, s);
    x.op2      = e.alusrc ? e.imm : rtv;
    x.store    = rtv;
    x.aluop    = e.aluop;
    x.shamt    = e.shamt;
    x.valid    = e.valid;
    x.regwrite = e.regwrite;
    x.memread  = e.memread;
    x.memwrite = e.memwrite;
    x.memtoreg = e.memtoreg;
    x.rd       = e.rd;
    x.stall    = needs_stall(e, s);
    return x;
  endfunction

  function automatic slot_t step(input slot_t e, input stim_t s);
    slot_t n;
    n = '0;
    if (s.rst || s.flush || needs_stall(e, s)) return n;
    n.valid    = s.id_valid;
    n.rs       = s.rs;
    n.rt       = s.rt;
    n.rd       = s.rd;
    n.rs_val   = s.rs_val;
    n.rt_val   = s.rt_val;
    n.imm      = s.imm;
    n.aluop    = s.aluop;
    n.shamt    = s.shamt;
    n.alusrc   = s.id_valid & s.alusrc;
    n.regwrite = s.id_valid & s.regwrite;
    n.memread  = s.id_valid & s.memread;
    n.memwrite = s.id_valid & s.memwrite;
    n.memtoreg = s.id_valid & s.memtoreg;
    return n;
  endfunction

  function automatic stim_t blank();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst      = ($urandom_range(0, 49) == 0);
    s.flush    = ($urandom_range(0, 7) == 0);
    s.id_valid = ($urandom_range(0, 4) != 0);
    s.rs_val   = $urandom;
    s.rt_val   = $urandom;
    s.imm      = $urandom;
    s.rs       = 5'($urandom_range(0, 7));
    s.rt       = 5'($urandom_range(0, 7));
    s.rd       = 5'($urandom_range(0, 7));
    s.aluop    = 6'($urandom_range(0, 20));
    s.shamt    = 5'($urandom);
    s.alusrc   = 1'($urandom);
    s.regwrite = 1'($urandom);
    s.memread  = ($urandom_range(0, 2) == 0);
    s.memwrite = ($urandom_range(0, 3) == 0);
    s.memtoreg = 1'($urandom);
    s.exw      = 1'($urandom);
    s.exrd     = 5'($urandom_range(0, 7));
    s.exres    = $urandom;
    s.mww      = 1'($urandom);
    s.mwrd     = 5'($urandom_range(0, 7));
    s.mwres    = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset              = s.rst;
    bus.flush          = s.flush;
    bus.id_valid       = s.id_valid;
    bus.id_rs_val      = s.rs_val;
    bus.id_rt_val      = s.rt_val;
    bus.id_imm         = s.imm;
    bus.id_rs          = s.rs;
    bus.id_rt          = s.rt;
    bus.id_rd          = s.rd;
    bus.id_aluop       = s.aluop;
    bus.id_shamt       = s.shamt;
    bus.id_alusrc      = s.alusrc;
    bus.id_regwrite    = s.regwrite;
    bus.id_memread     = s.memread;
    bus.id_memwrite    = s.memwrite;
    bus.id_memtoreg    = s.memtoreg;
    bus.exmem_regwrite = s.exw;
    bus.exmem_rd       = s.exrd;
    bus.exmem_result   = s.exres;
    bus.memwb_regwrite = s.mww;
    bus.memwb_rd       = s.mwrd;
    bus.memwb_result   = s.mwres;
  endtask

  // One clock of stimulus: expected outputs for this cycle go to the scoreboard.
  task automatic cycle(input stim_t s);
    @(posedge clk);
    m       = m_nxt;
    m_known = nxt_known;
    #1;
    drive(s);
    if (m_known) sb.push_back(expect_out(m, s));
    m_nxt     = step(m, s);
    nxt_known = m_known | s.rst;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("sb_op1",      bus.alu_op1,               mon_e.op1);
      chk("sb_op2",      bus.alu_op2,               mon_e.op2);
      chk("sb_store",    bus.ex_store_data,         mon_e.store);
      chk("sb_aluop",    32'(bus.alu_aluop),        32'(mon_e.aluop));
      chk("sb_shamt",    32'(bus.alu_shamt),        32'(mon_e.shamt));
      chk("sb_valid",    32'(bus.ex_valid),         32'(mon_e.valid));
      chk("sb_regwrite", 32'(bus.ex_regwrite),      32'(mon_e.regwrite));
      chk("sb_memread",  32'(bus.ex_memread),       32'(mon_e.memread));
      chk("sb_memwrite", 32'(bus.ex_memwrite),      32'(mon_e.memwrite));
      chk("sb_memtoreg", 32'(bus.ex_memtoreg),      32'(mon_e.memtoreg));
      chk("sb_rd",       32'(bus.ex_rd),            32'(mon_e.rd));
      chk("sb_stall",    32'(bus.stall),            32'(mon_e.stall));
    end
  end

  initial begin
    stim_t s, t, ld, use_i;

    // Reset held two cycles under random decode traffic.
    for (int i = 0; i < 2; i++) begin
      s = rnd();
      s.rst = 1'b1;
      cycle(s);
    end
    @(negedge clk);
    chk("rst_op1",   bus.alu_op1, 32'h0);
    chk("rst_op2",   bus.alu_op2, 32'h0);
    chk("rst_aluop", 32'(bus.alu_aluop), 32'h0);
    chk("rst_valid", 32'(bus.ex_valid), 32'h0);
    chk("rst_ctl",   32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg}),
        32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);

    // First instruction after release shows up one cycle after its capturing edge.
    s = blank();
    s.id_valid = 1'b1; s.rd = 5'd9; s.regwrite = 1'b1; s.aluop = 6'd1;
    cycle(s);
    @(negedge clk);
    chk("first_not_yet", 32'(bus.ex_valid), 32'h0);
    cycle(blank());
    @(negedge clk);
    chk("first_valid", 32'(bus.ex_valid), 32'h1);
    chk("first_rd",    32'(bus.ex_rd), 32'd9);

    // EX/MEM forwarding onto rs, then a zero destination that must not match.
    t = blank();
    t.id_valid = 1'b1; t.rs = 5'd3; t.rs_val = 32'd5; t.rt = 5'd1; t.alusrc = 1'b1;
    cycle(t);
    s = t; s.exw = 1'b1; s.exrd = 5'd3; s.exres = 32'h100;
    cycle(s);
    @(negedge clk);
    chk("exmem_fwd", bus.alu_op1, 32'h100);
    s = t; s.exw = 1'b1; s.exrd = 5'd0; s.exres = 32'h100;
    cycle(s);
    @(negedge clk);
    chk("exmem_rd0", bus.alu_op1, 32'd5);

    // Both forwarding sources target rt; EX/MEM has priority.
    t = blank();
    t.id_valid = 1'b1; t.rs = 5'd2; t.rt = 5'd7; t.rt_val = 32'h99;
    cycle(t);
    s = t; s.exw = 1'b1; s.exrd = 5'd7; s.exres = 32'hA; s.mww = 1'b1; s.mwrd = 5'd7;
    s.mwres = 32'hB;
    cycle(s);
    @(negedge clk);
    chk("dbl_exmem", bus.alu_op2, 32'hA);
    s.exw = 1'b0;
    cycle(s);
    @(negedge clk);
    chk("dbl_memwb", bus.alu_op2, 32'hB);

    // Load-use: one stall, one bubble, then MEM/WB forwarding of the loaded value.
    ld = blank();
    ld.id_valid = 1'b1; ld.memread = 1'b1; ld.regwrite = 1'b1; ld.memtoreg = 1'b1;
    ld.rd = 5'd4; ld.rs = 5'd1; ld.alusrc = 1'b1;
    cycle(ld);
    use_i = blank();
    use_i.id_valid = 1'b1; use_i.rs = 5'd4; use_i.rt = 5'd5; use_i.rs_val = 32'h1234;
    use_i.regwrite = 1'b1; use_i.rd = 5'd6; use_i.aluop = 6'h14;
    cycle(use_i);
    @(negedge clk);
    chk("lu_stall", 32'(bus.stall), 32'h1);
    cycle(use_i);
    @(negedge clk);
    chk("lu_bubble_valid", 32'(bus.ex_valid), 32'h0);
    chk("lu_bubble_rw",    32'(bus.ex_regwrite), 32'h0);
    chk("lu_stall_once",   32'(bus.stall), 32'h0);
    s = use_i; s.mww = 1'b1; s.mwrd = 5'd4; s.mwres = 32'h4444;
    cycle(s);
    @(negedge clk);
    chk("lu_fwd", bus.alu_op1, 32'h4444);
    chk("lu_valid", 32'(bus.ex_valid), 32'h1);

    // Immediate operand bypasses forwarding; store data still sees the forwarded rt.
    t = blank();
    t.id_valid = 1'b1; t.alusrc = 1'b1; t.imm = 32'hFFFF_FFF0; t.rt = 5'd9; t.rt_val = 32'h1;
    cycle(t);
    s = blank(); s.exw = 1'b1; s.exrd = 5'd9; s.exres = 32'h55;
    cycle(s);
    @(negedge clk);
    chk("imm_op2",   bus.alu_op2, 32'hFFFF_FFF0);
    chk("imm_store", bus.ex_store_data, 32'h55);

    // Flush coinciding with a load-use: stall still raised, flush's bubble wins.
    cycle(ld);
    s = use_i; s.flush = 1'b1;
    cycle(s);
    @(negedge clk);
    chk("fs_stall", 32'(bus.stall), 32'h1);
    cycle(blank());
    @(negedge clk);
    chk("fs_valid", 32'(bus.ex_valid), 32'h0);
    chk("fs_ctl",   32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg}),
        32'h0);
    chk("fs_aluop", 32'(bus.alu_aluop), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) cycle(rnd());
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection. It sits directly upstream of the 32-bit ALU. It captures decoded operands and control from the decode stage and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the ALU's OP1/OP2/AluOP/Shamt inputs and signals a one-cycle stall to fetch/decode on load-use.

## Interface
- `DW`, default 32: datapath width.
- `RW`, default 5: register-index width.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_rs_val`, `id_rt_val` in DW: register-file read data.
- `id_imm` in DW: sign/zero-extended immediate.
- `id_rs`, `id_rt`, `id_rd` in RW: source and destination indices; `id_rd` is already the write target.
- `id_aluop` in 6: ALU opcode (package encodings).
- `id_shamt` in 5: shift amount.
- `id_alusrc`, `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg` in 1 each: decoded control.
- `flush` in 1: branch/jump taken; squash the instruction entering EX.
- `exmem_regwrite` in 1, `exmem_rd` in RW, `exmem_result` in DW: EX/MEM forwarding source.
- `memwb_regwrite` in 1, `memwb_rd` in RW, `memwb_result` in DW: MEM/WB forwarding source.
- `alu_op1`, `alu_op2` out DW: forwarded ALU operands.
- `alu_aluop` out 6, `alu_shamt` out 5: to ALU.
- `ex_store_data` out DW: forwarded rt value for stores.
- `ex_valid`, `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_memtoreg` out 1; `ex_rd` out RW: registered control to EX/MEM.
- `stall` out 1: hold PC and IF/ID this cycle.

## Operation
- Registered state: valid, rs/rt/rd indices, rs/rt values, imm, aluop, shamt, and the five control bits.
- Load-use detect (combinational):
  - Condition: `ex_valid & ex_memread & ex_rd!=0`, and either `ex_rd==id_rs`, or `ex_rd==id_rt` with `id_alusrc==0` or `id_memwrite`.
  - `stall` is asserted only while `id_valid`.
- Update priority at each clock edge: reset > flush > stall > load.
  - reset or flush: insert a bubble. valid=0, all control bits 0, aluop=0 (ADD), data fields 0.
  - stall: insert a bubble into EX. Decode contents are not consumed; the upstream stage holds them.
  - load: capture all `id_*` fields. Captured valid = `id_valid`; control bits are gated by `id_valid`.
- Forwarding (combinational on registered indices), per source operand:
  - Use EX/MEM if `exmem_regwrite & exmem_rd!=0 & exmem_rd==src`.
  - Otherwise use MEM/WB under the same test.
  - Otherwise use the registered value.
  - EX/MEM wins when both match. Register 0 is never forwarded and always reads the registered value.
- `alu_op1` = forwarded rs.
- `alu_op2` = `ex_alusrc ? imm : forwarded rt`.
- `ex_store_data` = forwarded rt, regardless of alusrc.
- No arithmetic in this block; widths pass through unchanged.

## Timing
- Latency: decode inputs appear on `alu_*`/`ex_*` one cycle after the capturing edge. Forwarding adds no cycles.
- Load-use: exactly one bubble. In the next cycle the load is in MEM and its data arrives through MEM/WB forwarding.
- `stall` depends only on current registered EX state and `id_*` inputs. It has no path from `flush`. Upstream must give `flush` priority over `stall`.
- Reset mid-operation: the next edge clears everything. All outputs read 0 on the following cycle: `stall`=0, `alu_op1`/`alu_op2`=0, `alu_aluop`=0, all `ex_*`=0.
- Flush and stall in the same cycle: flush wins and a bubble is inserted.

## Structure
- Shared `mips_pkg`: ALU opcode constants (ADD=6'b000000 … SLL=6'b010100), `REG_ZERO`=5'd0, `DW`/`RW` defaults.
- One sub-module, `fwd_mux`:
  - Inputs: source index, registered value, both forwarding sources.
  - Output: forwarded value.
  - Instantiated twice (rs and rt).
- Hazard detection and the register live in the top module.

## Test plan
- Reset: hold `reset` 2 cycles with random `id_*`. All outputs are 0 and `stall`=0. After release, the first captured instruction appears one cycle later.
- EX/MEM forward:
  - Stimulus: capture rs=3 (rs_val=5), with exmem_regwrite=1, exmem_rd=3, exmem_result=0x100.
  - Expected: `alu_op1`=0x100.
  - With exmem_rd=0 and exmem_result=0x100, `alu_op1`=5.
- Double hazard: exmem_rd=memwb_rd=7, results 0xA and 0xB, rt=7, alusrc=0. Expected `alu_op2`=0xA. With exmem_regwrite=0, `alu_op2`=0xB.
- Load-use:
  - Stimulus: EX holds a memread with rd=4; decode presents rs=4.
  - Expected: `stall`=1 for one cycle, then a bubble (`ex_valid`=0, `ex_regwrite`=0).
  - The re-presented instruction then forwards `memwb_result`.
- Immediate path: alusrc=1, imm=0xFFFFFFF0, rt forwarded to 0x55. Expected `alu_op2`=0xFFFFFFF0 and `ex_store_data`=0x55.
- Flush+stall together: a load-use condition coincides with `flush`=1. Next cycle: `ex_valid`=0 and all control is 0.
